// File: rtl/cordic_controller_if.sv
// cordic_controller_if: job, result and core-step signals of the CORDIC iteration sequencer
interface cordic_controller_if #(
  parameter int p_WIDTH  = 32,
  parameter int p_ITER_W = 5
);
  logic               start, system_in, mode_in, out_ready;
  logic               busy, out_valid, core_system, core_mode;
  logic [p_WIDTH-1:0] x_in, y_in, z_in;
  logic [p_WIDTH-1:0] x_out, y_out, z_out;
  logic [p_WIDTH-1:0] core_x, core_y, core_z;
  logic [p_WIDTH-1:0] core_nx, core_ny, core_nz;
  logic [2:0]         ov_flags, core_ov;
  logic [p_ITER_W-1:0] ov_iter, core_shift;
  modport master (
    output start, x_in, y_in, z_in, system_in, mode_in, out_ready, core_nx, core_ny, core_nz, core_ov,
    input  busy, out_valid, x_out, y_out, z_out, ov_flags, ov_iter,
           core_x, core_y, core_z, core_shift, core_system, core_mode
  );
  modport slave (
    input  start, x_in, y_in, z_in, system_in, mode_in, out_ready, core_nx, core_ny, core_nz, core_ov,
    output busy, out_valid, x_out, y_out, z_out, ov_flags, ov_iter,
           core_x, core_y, core_z, core_shift, core_system, core_mode
  );
endinterface

// File: rtl/cordic_controller.sv
// cordic_controller: steps one CORDIC job through p_NUM_ITER core iterations with sticky overflow tracking.
// Define CORDIC_CTRL_OV_ABORT_EN to end a job on its first overflowing step.
module cordic_controller #(
  parameter int p_WIDTH    = 32,
  parameter int p_NUM_ITER = 30,
  parameter int p_ITER_W   = 5
) (
  input logic               clk,
  input logic               rstn,
  cordic_controller_if.slave io
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t              state_q, state_d;
  logic [p_WIDTH-1:0]  x_q, x_d, y_q, y_d, z_q, z_d;
  logic [p_ITER_W-1:0] step_q, step_d, shift_q, shift_d, ov_iter_q, ov_iter_d;
  logic [2:0]          ov_flags_q, ov_flags_d;
  logic                sys_q, sys_d, mode_q, mode_d, rep_q, rep_d;
  logic                busy_q, busy_d, valid_q, valid_d, hold, last;
  // hyperbolic convergence needs shifts 4 and 13 issued twice
  assign hold = !sys_q && !rep_q && (shift_q == p_ITER_W'(4) || shift_q == p_ITER_W'(13));
`ifdef CORDIC_CTRL_OV_ABORT_EN
  assign last = step_q == p_ITER_W'(p_NUM_ITER - 1) || io.core_ov != 3'b000;
`else
  assign last = step_q == p_ITER_W'(p_NUM_ITER - 1);
`endif
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    step_d     = step_q;
    shift_d    = shift_q;
    rep_d      = rep_q;
    sys_d      = sys_q;
    mode_d     = mode_q;
    ov_flags_d = ov_flags_q;
    ov_iter_d  = ov_iter_q;
    busy_d     = busy_q;
    valid_d    = valid_q;
    if (state_q == IDLE && io.start) begin
      state_d    = RUN;
      x_d        = io.x_in;
      y_d        = io.y_in;
      z_d        = io.z_in;
      sys_d      = io.system_in;
      mode_d     = io.mode_in;
      step_d     = '0;
      shift_d    = io.system_in ? '0 : p_ITER_W'(1);
      rep_d      = 1'b0;
      ov_flags_d = '0;
      ov_iter_d  = '1;
      busy_d     = 1'b1;
    end else if (state_q == RUN) begin
      x_d        = io.core_nx;
      y_d        = io.core_ny;
      z_d        = io.core_nz;
      step_d     = step_q + p_ITER_W'(1);
      shift_d    = hold ? shift_q : shift_q + p_ITER_W'(1);
      rep_d      = hold;
      ov_flags_d = ov_flags_q | io.core_ov;
      ov_iter_d  = (io.core_ov != 3'b000 && ov_flags_q == 3'b000) ? step_q : ov_iter_q;
      state_d    = last ? DONE : RUN;
    end else if (state_q == DONE) begin
      valid_d = 1'b1;
      if (valid_q && io.out_ready) begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      step_q     <= '0;
      shift_q    <= '0;
      rep_q      <= 1'b0;
      sys_q      <= 1'b0;
      mode_q     <= 1'b0;
      ov_flags_q <= '0;
      ov_iter_q  <= '1;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      step_q     <= step_d;
      shift_q    <= shift_d;
      rep_q      <= rep_d;
      sys_q      <= sys_d;
      mode_q     <= mode_d;
      ov_flags_q <= ov_flags_d;
      ov_iter_q  <= ov_iter_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
    end
  end
  assign io.busy        = busy_q;
  assign io.out_valid   = valid_q;
  assign io.x_out       = x_q;
  assign io.y_out       = y_q;
  assign io.z_out       = z_q;
  assign io.core_x      = x_q;
  assign io.core_y      = y_q;
  assign io.core_z      = z_q;
  assign io.core_shift  = shift_q;
  assign io.core_system = sys_q;
  assign io.core_mode   = mode_q;
  assign io.ov_flags    = ov_flags_q;
  assign io.ov_iter     = ov_iter_q;
endmodule

// File: tb/tb_cordic_controller.sv
// tb_cordic_controller: directed checks of the CORDIC sequencer against a behavioural one-step core
module tb_cordic_controller;
  localparam int W = 32, IW = 5, N = 30;
  logic clk = 1'b0, rstn = 1'b0;
  logic [2:0] ov_force = 3'b000;
  int n_chk = 0, n_pass = 0, lat, bad;
  int trace [N];
  int at_c [32];
  int at_h [32];
  int hsh [N] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13,
                  14, 15, 16, 17, 18, 19, 20, 21, 22, 23, 24, 25, 26, 27, 28};
  logic [W-1:0] hx, hy, hz;
  logic signed [W-1:0] cx, cy, cz, sx, sy, a;
  logic d;

  cordic_controller_if #(.p_WIDTH(W), .p_ITER_W(IW)) io ();
  cordic_controller #(.p_WIDTH(W), .p_NUM_ITER(N), .p_ITER_W(IW)) dut (.clk(clk), .rstn(rstn), .io(io));

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 32; i++) begin
      at_c[i] = $rtoi($atan(2.0 ** (-i)) / (2.0 * 3.141592653589793) * 4294967296.0 + 0.5);
      at_h[i] = 0;
      if (i > 0) at_h[i] = $rtoi(0.5 * $ln((1.0 + 2.0 ** (-i)) / (1.0 - 2.0 ** (-i))) * 1073741824.0 + 0.5);
    end
  end

  assign cx = $signed(io.core_x);
  assign cy = $signed(io.core_y);
  assign cz = $signed(io.core_z);
  assign sx = cx >>> io.core_shift;
  assign sy = cy >>> io.core_shift;
  assign a  = io.core_system ? at_c[io.core_shift] : at_h[io.core_shift];
  assign d  = io.core_mode ? !cz[W-1] : cy[W-1];
  assign io.core_nx = io.core_system ? (d ? cx - sy : cx + sy) : (d ? cx + sy : cx - sy);
  assign io.core_ny = d ? cy + sx : cy - sx;
  assign io.core_nz = d ? cz - a : cz + a;
  assign io.core_ov = ov_force;

  function automatic logic [W-1:0] q30(input real r);
    return W'($rtoi(r * 1073741824.0 + (r < 0.0 ? -0.5 : 0.5)));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic near(input string tag, input longint obs, input longint exp, input longint tol);
    longint diff;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    n_chk++;
    assert (diff <= tol) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d tol %0d", tag, obs, exp, tol);
  endtask

  task automatic run_job(input logic [W-1:0] x, y, z, input logic sys, md, input int ov_step);
    io.x_in = x; io.y_in = y; io.z_in = z; io.system_in = sys; io.mode_in = md; io.start = 1'b1;
    @(posedge clk);
    #1 io.start = 1'b0;
    io.x_in = $urandom; io.y_in = $urandom; io.z_in = $urandom; io.system_in = ~sys; io.mode_in = ~md;
    lat = 0;
    while (!io.out_valid && lat < 200) begin
      if (lat < N) trace[lat] = int'(io.core_shift);
      ov_force = (lat == ov_step) ? 3'b010 : 3'b000;
      @(posedge clk);
      #1 lat++;
    end
    ov_force = 3'b000;
  endtask

  task automatic consume();
    io.out_ready = 1'b1;
    @(posedge clk);
    #1 io.out_ready = 1'b0;
    chk("consume busy", io.busy, 0);
    chk("consume valid", io.out_valid, 0);
  endtask

  initial begin
    io.start = 1'b0; io.x_in = '0; io.y_in = '0; io.z_in = '0;
    io.system_in = 1'b0; io.mode_in = 1'b0; io.out_ready = 1'b0;
    #12;
    chk("rst busy", io.busy, 0);
    chk("rst valid", io.out_valid, 0);
    chk("rst ov_iter", io.ov_iter, 5'h1f);
    chk("rst ov_flags", io.ov_flags, 0);
    chk("rst x_out", io.x_out, 0);
    chk("rst core_shift", io.core_shift, 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    run_job(q30(0.6072529), '0, 32'h2000_0000, 1'b1, 1'b1, -1);
    chk("rot latency", lat, 31);
    chk("rot busy", io.busy, 1);
    near("rot x", $signed(io.x_out), $signed(q30(0.7071068)), 1074);
    near("rot y", $signed(io.y_out), $signed(q30(0.7071068)), 1074);
    near("rot z", $signed(io.z_out), 0, 64);
    chk("rot ov_flags", io.ov_flags, 0);
    chk("rot ov_iter", io.ov_iter, 5'h1f);
    bad = 0;
    for (int k = 0; k < N; k++) if (trace[k] != k) bad++;
    chk("circ shift trace", bad, 0);
    consume();
    run_job('0, q30(0.1), '0, 1'b1, 1'b0, -1);
    near("vec x", $signed(io.x_out), $signed(q30(0.16468)), 10737);
    near("vec y", $signed(io.y_out), 0, 64);
    near("vec z", $signed(io.z_out), 64'sh4000_0000, 119);
    consume();
    run_job(q30(1.0), q30(0.5), '0, 1'b0, 1'b0, -1);
    chk("hyp latency", lat, 31);
    near("hyp z", $signed(io.z_out), $signed(q30(0.549306)), 1074);
    bad = 0;
    for (int k = 0; k < N; k++) if (trace[k] != hsh[k]) bad++;
    chk("hyp shift trace", bad, 0);
    hx = io.x_out; hy = io.y_out; hz = io.z_out;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      io.start = 1'b1; io.x_in = $urandom; io.system_in = 1'b1; io.mode_in = 1'b1;
      @(posedge clk);
      #1 if (io.out_valid !== 1'b1 || io.busy !== 1'b1 || io.x_out !== hx || io.y_out !== hy || io.z_out !== hz) bad++;
    end
    chk("hold window", bad, 0);
    consume();
    io.start = 1'b0;
    run_job(q30(0.6072529), '0, 32'h2000_0000, 1'b1, 1'b1, 7);
    chk("ov flags", io.ov_flags, 3'b010);
    chk("ov iter", io.ov_iter, 7);
`ifdef CORDIC_CTRL_OV_ABORT_EN
    chk("ov latency", lat, 9);
`else
    chk("ov latency", lat, 31);
`endif
    consume();
    io.x_in = q30(0.6072529); io.y_in = '0; io.z_in = 32'h2000_0000;
    io.system_in = 1'b1; io.mode_in = 1'b1; io.start = 1'b1;
    @(posedge clk);
    #1 io.start = 1'b0;
    ov_force = 3'b001;
    @(posedge clk);
    #1 ov_force = 3'b000;
    repeat (11) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("midrst valid", io.out_valid, 0);
    chk("midrst busy", io.busy, 0);
    chk("midrst ov_iter", io.ov_iter, 5'h1f);
    chk("midrst ov_flags", io.ov_flags, 0);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
    run_job(q30(0.6072529), '0, 32'h2000_0000, 1'b1, 1'b1, -1);
    chk("fresh latency", lat, 31);
    near("fresh x", $signed(io.x_out), $signed(q30(0.7071068)), 1074);
    chk("fresh ov_iter", io.ov_iter, 5'h1f);
    consume();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
